iir_decim_buf: RTL and testbench
================================

IIR_DECIM_BUF -- requirements
Module: iir_decim_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in samples; power of two, 2..1024.
REQ-002 SHALL have parameter Nd, default 18, sample width in bits; matches the IIR filter output word.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port dv_in  input  1  sample strobe from the upstream IIR filter dv_out.
REQ-006 SHALL have port d_in  input  Nd  signed sample from the upstream IIR filter d_out.
REQ-007 SHALL have port decim  input  8  decimation factor; 0 and 1 both mean keep every sample.
REQ-008 SHALL have port clr_ovf  input  1  clears the overflow flag (and counter, if built).
REQ-009 SHALL have port m_tvalid  output  1  FIFO head valid.
REQ-010 SHALL have port m_tready  input  1  downstream accept.
REQ-011 SHALL have port m_tdata  output  Nd  FIFO head sample.
REQ-012 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 SHALL have port ovf  output  1  sticky overflow flag.
REQ-014 SHALL have port ovf_cnt  output  16  dropped-sample count.

Function
REQ-015 SHALL hold a phase counter ph, 8 bits, advanced only on cycles with dv_in=1.
REQ-016 SHALL mark a dv_in sample as kept when ph==0; after each dv_in, ph SHALL become 0 if ph>=decim-1 or decim<=1, else ph+1.
REQ-017 SHALL take a change on decim without a restart; the new value applies from the next dv_in comparison.
REQ-018 SHALL write a kept sample into the FIFO on the same edge when level<DEPTH, or when level==DEPTH and m_tvalid&m_tready in that cycle.
REQ-019 SHALL drop a kept sample arriving when full with no same-cycle read, and set ovf=1 on that edge; the FIFO contents SHALL be unchanged.
REQ-020 SHALL treat a handshake as m_tvalid&m_tready; each handshake pops exactly one sample.
REQ-021 SHALL present the FIFO head with show-ahead behaviour: m_tdata is valid whenever m_tvalid=1 and stays stable until popped.
REQ-022 SHALL raise m_tvalid in the cycle after the edge that writes into an empty FIFO (write-to-valid latency 1 clock).
REQ-023 SHALL deassert m_tvalid in the cycle after the edge that pops the last sample, unless a write occurs on that same edge.
REQ-024 SHALL keep level unchanged on a simultaneous write and pop; otherwise it SHALL change by +1 or -1 per edge.
REQ-025 SHALL wrap the read and write pointers modulo DEPTH with no gap or duplication.
REQ-026 SHALL clear ovf on an edge with clr_ovf=1; if a drop and clr_ovf coincide, ovf SHALL end 1.
REQ-027 SHALL never pass sample values through arithmetic; data is bit-exact from d_in to m_tdata.

Reset
REQ-028 SHALL, while rst=1, force m_tvalid=0, level=0, ovf=0, ovf_cnt=0, ph=0, and both pointers to 0.
REQ-029 SHALL discard FIFO contents and any in-flight sample on reset mid-operation; the first dv_in after release is kept.
REQ-030 SHALL not require m_tdata to have a reset value; FIFO RAM is not reset.

Configuration
REQ-031 SHALL, with macro IIR_DECIM_OVF_CNT_EN defined, increment ovf_cnt on every dropped sample, saturating at 16'hFFFF, and clear it with clr_ovf; a simultaneous drop and clr_ovf SHALL yield 1.
REQ-032 SHALL, without IIR_DECIM_OVF_CNT_EN, tie ovf_cnt to 0 and contain no counter logic.

Verification
REQ-033 SHALL cover: decim=4, 12 dv_in samples with values 0..11, m_tready=1 -> outputs 0,4,8 only, each m_tvalid one clock after its write edge.
REQ-034 SHALL cover: decim=1, m_tready=0, 20 samples into DEPTH=16 -> level=16, ovf=1, ovf_cnt=4 (macro on) or 0 (macro off); then drain -> samples 0..15 in order.
REQ-035 SHALL cover: full FIFO with dv_in and m_tready both high on one edge -> sample accepted, level stays 16, ovf stays 0.
REQ-036 SHALL cover: decim changed from 3 to 2 mid-stream after sample 3 (ph=1) -> next kept sample is 5 (ph 1->0 at sample 4), then 7.
REQ-037 SHALL cover: rst pulsed with level=7 mid-burst -> m_tvalid=0 and level=0 next cycle; first dv_in after release appears as the next output.
REQ-038 SHALL cover: clr_ovf coincident with a drop -> ovf=1, ovf_cnt=1 (macro on).

Source files
------------

// File: rtl/iir_decim_buf.sv
// Decimating show-ahead FIFO behind an IIR filter output; keeps every decim-th strobe.
// Optional macro IIR_DECIM_OVF_CNT_EN builds a saturating dropped-sample counter on ovf_cnt.
module iir_decim_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned Nd    = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dv_in,
    input  logic [Nd-1:0]              d_in,
    input  logic [7:0]                 decim,
    input  logic                       clr_ovf,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [Nd-1:0]              m_tdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    output logic [15:0]                ovf_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [Nd-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [7:0]    ph;

    logic          keep_c;
    logic          pop_c;
    logic          wr_c;
    logic          drop_c;
    logic [LW-1:0] level_n;
    logic [AW-1:0] rd_ptr_n;
    logic [Nd-1:0] head_n;

    // Kept/write/drop decisions and the next registered head word
    always_comb begin
        keep_c   = dv_in && (ph == 8'd0);
        pop_c    = m_tvalid && m_tready;
        wr_c     = keep_c && ((level != FULL) || pop_c);
        drop_c   = keep_c && (level == FULL) && !pop_c;
        level_n  = level;
        rd_ptr_n = rd_ptr;
        head_n   = m_tdata;
        if (wr_c && !pop_c) begin
            level_n = level + LW'(1);
        end else if (!wr_c && pop_c) begin
            level_n = level - LW'(1);
        end
        if (pop_c) begin
            rd_ptr_n = rd_ptr + AW'(1);
        end
        if (level_n != '0) begin
            // A write into an otherwise-empty FIFO bypasses the RAM straight to the head
            if (wr_c && ((level - LW'(pop_c)) == '0)) begin
                head_n = d_in;
            end else begin
                head_n = mem[rd_ptr_n];
            end
        end
    end

    // Sample storage, not reset
    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem[wr_ptr] <= d_in;
        end
    end

    // Head register carries no reset value
    always_ff @(posedge clk) begin
        m_tdata <= head_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            m_tvalid <= 1'b0;
            ph       <= 8'd0;
            ovf      <= 1'b0;
        end else begin
            rd_ptr   <= rd_ptr_n;
            level    <= level_n;
            m_tvalid <= (level_n != '0);
            if (wr_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (dv_in) begin
                ph <= ((decim <= 8'd1) || (ph >= decim - 8'd1)) ? 8'd0 : ph + 8'd1;
            end
            if (drop_c) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef IIR_DECIM_OVF_CNT_EN
    logic [15:0] cnt;

    // Saturating drop counter; a drop coinciding with a clear restarts at one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 16'd0;
        end else if (drop_c) begin
            if (clr_ovf) begin
                cnt <= 16'd1;
            end else if (cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
        end else if (clr_ovf) begin
            cnt <= 16'd0;
        end
    end

    assign ovf_cnt = cnt;
`else
    assign ovf_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_iir_decim_buf.sv
// Scoreboard bench for iir_decim_buf: directed vectors push expected head words,
// a negedge monitor pops and compares on every handshake.
module tb_iir_decim_buf;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned ND    = 18;

    logic            clk = 1'b0;
    logic            rst;
    logic            dv_in;
    logic [ND-1:0]   d_in;
    logic [7:0]      decim;
    logic            clr_ovf;
    logic            m_tvalid;
    logic            m_tready;
    logic [ND-1:0]   m_tdata;
    logic [4:0]      level;
    logic            ovf;
    logic [15:0]     ovf_cnt;

    int checks = 0;
    int errors = 0;
    logic [ND-1:0] sb [$];

`ifdef IIR_DECIM_OVF_CNT_EN
    localparam logic [15:0] CNT_AFTER_4 = 16'd4;
    localparam logic [15:0] CNT_AFTER_1 = 16'd1;
`else
    localparam logic [15:0] CNT_AFTER_4 = 16'd0;
    localparam logic [15:0] CNT_AFTER_1 = 16'd0;
`endif

    iir_decim_buf #(.DEPTH(DEPTH), .Nd(ND)) dut (
        .clk      (clk),
        .rst      (rst),
        .dv_in    (dv_in),
        .d_in     (d_in),
        .decim    (decim),
        .clr_ovf  (clr_ovf),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .level    (level),
        .ovf      (ovf),
        .ovf_cnt  (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [ND-1:0] v);
        dv_in = 1'b1;
        d_in  = v;
        tick();
        dv_in = 1'b0;
    endtask

    task automatic drain();
        m_tready = 1'b1;
        for (int i = 0; i < 64 && level != 5'd0; i++) tick();
        tick();
        check("drain_done", 32'(level), 32'd0);
        m_tready = 1'b0;
    endtask

    // Monitor: a handshake is visible at negedge and commits on the next rising edge
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %0d expected none", m_tdata);
            end else begin
                logic [ND-1:0] e;
                e = sb.pop_front();
                if (m_tdata !== e) begin
                    errors++;
                    $display("FAIL m_tdata: got %0d expected %0d", m_tdata, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; dv_in = 1'b0; d_in = '0; decim = 8'd4; clr_ovf = 1'b0; m_tready = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(m_tvalid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // decim=4: only 0,4,8 emerge, each valid one clock after its write edge
        sb.push_back(18'd0); sb.push_back(18'd4); sb.push_back(18'd8);
        m_tready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(ND'(i));
            check($sformatf("d4_valid_%0d", i), 32'(m_tvalid), (i % 4 == 0) ? 32'd1 : 32'd0);
        end
        tick();
        check("d4_sb_empty", 32'(sb.size()), 32'd0);
        m_tready = 1'b0;

        // decim=1, no reads: 20 in, 16 kept, 4 dropped
        decim = 8'd1;
        for (int i = 0; i < 16; i++) sb.push_back(ND'(i));
        for (int i = 0; i < 20; i++) send(ND'(i));
        check("full_level", 32'(level), 32'd16);
        check("full_ovf", 32'(ovf), 32'd1);
        check("full_ovf_cnt", 32'(ovf_cnt), 32'(CNT_AFTER_4));
        drain();
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check("clr_ovf", 32'(ovf), 32'd0);
        check("clr_ovf_cnt", 32'(ovf_cnt), 32'd0);

        // Full FIFO with simultaneous write and pop
        for (int i = 0; i < 17; i++) sb.push_back(ND'(200 + i));
        for (int i = 0; i < 16; i++) send(ND'(200 + i));
        check("fill_level", 32'(level), 32'd16);
        m_tready = 1'b1;
        send(ND'(216));
        m_tready = 1'b0;
        check("simul_level", 32'(level), 32'd16);
        check("simul_ovf", 32'(ovf), 32'd0);
        drain();
        check("simul_sb_empty", 32'(sb.size()), 32'd0);

        // decim 3 -> 2 after sample 3: kept 0,3,5,7
        decim = 8'd3;
        sb.push_back(18'd0); sb.push_back(18'd3); sb.push_back(18'd5); sb.push_back(18'd7);
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) decim = 8'd2;
            send(ND'(i));
        end
        tick(); tick();
        check("dchg_sb_empty", 32'(sb.size()), 32'd0);
        m_tready = 1'b0;

        // Phase is 1 here, so the first of 8 strobes is skipped under decim=1
        decim = 8'd1;
        for (int i = 0; i < 8; i++) send(ND'(400 + i));
        check("pre_rst_level", 32'(level), 32'd7);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(m_tvalid), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        rst = 1'b0;
        tick();
        decim = 8'd4;
        sb.push_back(18'd500);
        send(ND'(500));
        check("post_rst_valid", 32'(m_tvalid), 32'd1);
        m_tready = 1'b1;
        send(ND'(501));
        tick();
        check("post_rst_sb_empty", 32'(sb.size()), 32'd0);
        check("post_rst_level", 32'(level), 32'd0);
        m_tready = 1'b0;

        // Drop coinciding with clr_ovf leaves the flag set and count at one
        decim = 8'd1;
        send(ND'(0));
        for (int i = 0; i < 16; i++) sb.push_back(ND'(600 + i));
        for (int i = 0; i < 16; i++) send(ND'(600 + i));
        clr_ovf = 1'b1;
        send(ND'(616));
        clr_ovf = 1'b0;
        check("coinc_ovf", 32'(ovf), 32'd1);
        check("coinc_ovf_cnt", 32'(ovf_cnt), 32'(CNT_AFTER_1));
        check("coinc_level", 32'(level), 32'd16);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check("coinc_clr_ovf", 32'(ovf), 32'd0);
        drain();
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
